// File: rtl/axi_slave_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_rx_fifo_if
//  Description : Master-side input and consumer-side output handshakes, plus
//                status, of the receive FIFO stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_slave_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    logic                       m_valid;
    logic [DATA_W-1:0]          m_s_data;
    logic                       s_ready;
    logic                       d_valid;
    logic [DATA_W-1:0]          d_data;
    logic                       d_ready;
    logic [$clog2(DEPTH):0]     fill;
    logic [15:0]                rx_count;

    // Environment side: beat producer, beat consumer and status observer.
    modport master (
        output m_valid,
        output m_s_data,
        input  s_ready,
        input  d_valid,
        input  d_data,
        output d_ready,
        input  fill,
        input  rx_count
    );

    // FIFO side.
    modport slave (
        input  m_valid,
        input  m_s_data,
        output s_ready,
        output d_valid,
        output d_data,
        input  d_ready,
        output fill,
        output rx_count
    );
endinterface : axi_slave_rx_fifo_if
`default_nettype wire

// File: rtl/axi_slave_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_rx_fifo
//  Description : First-word-fall-through receive FIFO between master_logic and
//                the slave-side consumer, with fill level and beat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    axi_slave_rx_fifo_if.slave  rx
);

    localparam int                  c_PTR_W  = $clog2(DEPTH);
    localparam int                  c_FILL_W = c_PTR_W + 1;
    localparam logic [c_FILL_W-1:0] c_FULL   = c_FILL_W'(DEPTH);

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_FILL_W-1:0]    r_fill;
    logic [15:0]            r_rx_count;
    logic                   r_s_ready;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_d_valid;
    logic [c_FILL_W-1:0]    w_fill_nxt;

    assign w_d_valid = (r_fill != '0);
    assign w_push    = rx.m_valid & r_s_ready;
    assign w_pop     = w_d_valid & rx.d_ready;

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + c_FILL_W'(1);
        end else if (!w_push && w_pop) begin
            w_fill_nxt = r_fill - c_FILL_W'(1);
        end
    end

    // Storage is deliberately left out of reset; pointers alone define contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx.m_s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_rx_count <= '0;
            r_s_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                r_rx_count <= r_rx_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_fill    <= w_fill_nxt;
            // Looking at the next fill lets ready fall on the very edge that fills the FIFO.
            r_s_ready <= (w_fill_nxt != c_FULL);
        end
    end

    assign rx.s_ready  = r_s_ready;
    assign rx.d_valid  = w_d_valid;
    assign rx.d_data   = r_mem[r_rd_ptr];
    assign rx.fill     = r_fill;
    assign rx.rx_count = r_rx_count;

endmodule : axi_slave_rx_fifo
`default_nettype wire

// File: doc/axi_slave_rx_fifo.md
Name: axi_slave_rx_fifo

Overview:
- Receive-side stage directly downstream of master_logic.
- Accepts 8-bit beats from the master over its valid/ready handshake (m_valid, m_s_data, s_ready).
- Buffers beats in a small first-word-fall-through FIFO and presents them to the slave-side consumer on a second valid/ready interface.
- Reports FIFO fill level and a running count of accepted beats.

Parameters:
DATA_W, 8, beat width; must match master_logic data width.
DEPTH, 8, FIFO entries; power of 2, minimum 2. Pointer width is log2(DEPTH); fill width is log2(DEPTH)+1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
m_valid  input  1  master beat valid.
m_s_data  input  DATA_W  master beat data.
s_ready  output  1  slave ready to master; registered.
d_valid  output  1  buffered beat available to consumer.
d_data  output  DATA_W  head-of-FIFO beat; meaningful only while d_valid=1.
d_ready  input  1  consumer accepts head beat.
fill  output  log2(DEPTH)+1  number of beats currently stored.
rx_count  output  16  total beats accepted since reset; wraps.

Behaviour:
- Reset (rst=1, asynchronous):
  - read pointer, write pointer, fill, rx_count all 0; s_ready=0; d_valid=0.
  - Storage array is not reset.
  - Reset mid-operation discards all buffered beats immediately.
- First rising edge after rst deasserts: s_ready becomes 1.
- Handshakes:
  - push = m_valid & s_ready, sampled at the rising edge.
  - pop = d_valid & d_ready, sampled at the rising edge.
- Push:
  - m_s_data is written to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH; rx_count increments, wrapping 0xFFFF -> 0x0000.
- Pop: rd_ptr increments modulo DEPTH.
- Fill: next fill = fill + push - pop. Simultaneous push and pop leaves fill unchanged and moves both pointers.
- d_valid = (fill != 0); d_data = mem[rd_ptr] (first-word-fall-through).
- No combinational path from m_valid, m_s_data or d_ready to any output. All outputs are functions of registered state only.
- Latency: a beat pushed at edge N is visible on d_valid/d_data after edge N; the consumer can pop it at edge N+1 at the earliest.
- s_ready update:
  - s_ready register next value = (next fill != DEPTH), evaluated at each edge outside reset.
  - s_ready therefore drops in the same cycle the FIFO becomes full and rises the cycle after the first pop from full.
- Full (fill=DEPTH): s_ready=0, so no push occurs; a pop is still allowed. Overflow is impossible by construction.
- Empty (fill=0): d_valid=0, so no pop occurs regardless of d_ready. A push into empty is never bypassed in the same cycle.
- Master holding m_valid=1 while s_ready=0: no state change on the input side. Data may change freely; no protocol checking in this block.
- Ordering: strict FIFO; pointer wrap at DEPTH-1 -> 0 must preserve order.

Test Plan:
- Reset 20 ns, then m_valid=1 with m_s_data = 0xB0..0xB5 one per cycle, d_ready=1 -> d_data sequence B0..B5 one cycle behind input; fill never exceeds 1; rx_count=6.
- d_ready=0, push 0x10..0x17 -> s_ready low in the cycle fill reaches 8; 0x18 held on m_s_data is not accepted; rx_count=8.
- Then d_ready=1 for one cycle -> 0x10 popped, fill=7, s_ready=1 next cycle, 0x18 accepted.
- FIFO at fill=4 with m_valid=1 and d_ready=1 for 10 cycles -> fill stays 4; output order is continuous; pointers wrap with no lost or duplicated beat.
- Assert rst asynchronously (mid-cycle) with fill=5 -> d_valid=0, fill=0, rx_count=0, s_ready=0 immediately. After release, push 0xA5 -> first d_data=0xA5, with no stale data.
- Push 65537 beats with d_ready=1 -> rx_count reads 0x0001 and d_data stream stays intact.
